reg_file_multi: RTL
===================

Name: reg_file_multi

Overview:
- Parametrised successor to the fixed 32x32, 2-read/1-write register file.
- Generalises data width, depth and read-port count.
- Adds byte-lane write enables, optional hardwired zero register, and write-to-read bypass.
- Adds a selectable registered-read mode and a sequential clear engine (FSM) for bulk zeroing without a reset.
- Sits in the datapath between decode (selects) and execute (read operands, writeback data).

Parameters:
- DATA_W, 32, data width in bits; must be a multiple of 8.
- DEPTH, 32, number of registers; 2..256.
- NUM_RD, 2, number of independent read ports; 1..4.
- ZERO_REG, 1, 1 = register 0 reads as 0 and ignores writes.
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read port.
- READ_REG, 0, 0 = combinational read; 1 = read data registered (1-cycle latency).
- ADDR_W, $clog2(DEPTH), derived select width; not overridden.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- regReadSel  in  NUM_RD*ADDR_W  packed read selects; port k uses bits [k*ADDR_W +: ADDR_W].
- regReadData  out  NUM_RD*DATA_W  packed read data; port k uses bits [k*DATA_W +: DATA_W].
- regWriteSel  in  ADDR_W  write select.
- writeEnable  in  1  write strobe, active high.
- byteEnable  in  DATA_W/8  per-byte write mask; bit b covers bits [8b+7:8b].
- writeData  in  DATA_W  write data.
- clearReq  in  1  single-cycle pulse; starts bulk clear.
- clearBusy  out  1  high while the clear engine runs.
- writeReady  out  1  equals !clearBusy; external writes are accepted only when high.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - all DEPTH registers cleared to 0;
  - regReadData registers (READ_REG=1) cleared to 0;
  - FSM goes to IDLE, clear counter = 0;
  - clearBusy = 0, writeReady = 1.
  - Reset overrides everything, including a clear in progress.
- Write, when writeEnable & writeReady & (regWriteSel < DEPTH) & !(ZERO_REG & regWriteSel==0):
  - at the edge, each byte with byteEnable[b]=1 takes writeData's byte; the other bytes are unchanged.
  - byteEnable=0 means no change.
- Read, port k, sel = that port's select:
  - base = storage[sel]; 0 if sel >= DEPTH or (ZERO_REG & sel==0).
  - If BYPASS=1 and an accepted write targets sel this cycle: value = base with the enabled bytes replaced by writeData bytes. Otherwise value = base.
  - READ_REG=0: regReadData shows value combinationally, in the same cycle.
  - READ_REG=1: value is registered at the edge and appears next cycle. Without bypass, the registered value is the pre-write contents.
- Multiple read ports with the same select return identical data.
- Clear FSM:
  - IDLE: clearReq=1 -> CLEAR, counter = 0, clearBusy = 1 from the next cycle.
  - CLEAR: each cycle storage[counter] = 0 and counter increments. After writing DEPTH-1 -> IDLE, clearBusy = 0. The sequence takes exactly DEPTH busy cycles.
  - A write presented in the cycle clearReq is sampled in IDLE is still accepted.
  - Writes presented while busy are dropped, with no queueing.
  - clearReq while busy is ignored.
  - Reads during CLEAR return the current storage: already-cleared entries read 0, others their old value. Bypass is inactive because no write is accepted.
- No X propagation: out-of-range selects are defined as above.

Decomposition:
- Shared package regfile_pkg:
  - clear FSM state enum (IDLE, CLEAR);
  - function byte_merge(old, new, mask) used by both the write path and the bypass path;
  - localparam BYTES = DATA_W/8.
- Sub-module reg_file_read_port: one instance per read port via generate. It does select decode, zero/out-of-range masking, bypass merge and the optional output register.

Test Plan:
- Reset then read all regs: rst_n low 1 cycle -> every regReadData = 0, clearBusy = 0, writeReady = 1.
- Full write/readback: write reg i = 32'hFFFF000F - i for i = 1..31 with byteEnable = 4'hF, then read on both ports -> exact values. Writing reg 0 with 32'hDEADBEEF reads 0 (ZERO_REG=1).
- Byte enables: reg 5 = 32'h11223344, then write 32'hAABBCCDD with byteEnable = 4'b0101 -> reg 5 reads 32'h11BB33DD.
- Bypass: same-cycle write of 32'h0000FFF0 to reg 7 while port 1 selects 7 -> READ_REG=0: same-cycle data 32'h0000FFF0. READ_REG=1: next-cycle data 32'h0000FFF0. BYPASS=0, READ_REG=0: old value.
- Clear engine (DEPTH=32): pulse clearReq -> clearBusy high for exactly 32 cycles. A write to reg 3 mid-clear is dropped, so reg 3 reads 0 afterwards. Reg 20 reads its old value until the cycle after counter=20.
- Reset mid-clear: rst_n low at counter = 10 -> next cycle clearBusy = 0, FSM IDLE, all regs 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file and its read ports.
package regfile_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } clr_state_e;

   // byte_merge works on a fixed wide vector so one function serves every DATA_W;
   // callers zero-extend their operands and truncate the result.
   localparam int MAX_DW    = 1024;
   localparam int MAX_BYTES = MAX_DW / 8;

   function automatic logic [MAX_DW-1:0] byte_merge(
      input logic [MAX_DW-1:0]    old_v,
      input logic [MAX_DW-1:0]    new_v,
      input logic [MAX_BYTES-1:0] mask
   );
      logic [MAX_DW-1:0] res;
      res = old_v;
      for (int b = 0; b < MAX_BYTES; b++) begin
         if (mask[b]) res[8*b +: 8] = new_v[8*b +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/reg_file_read_port.sv
// One read port: select decode, zero/out-of-range masking, write bypass and optional output register.
module reg_file_read_port
   import regfile_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int DEPTH    = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1,
   parameter int READ_REG = 0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [ADDR_W-1:0]   sel_i,
   input  logic [DATA_W-1:0]   mem_i [DEPTH],
   input  logic                wr_acc_i,
   input  logic [ADDR_W-1:0]   wr_sel_i,
   input  logic [DATA_W/8-1:0] wr_be_i,
   input  logic [DATA_W-1:0]   wr_data_i,
   output logic [DATA_W-1:0]   rd_data_o
);

   logic              in_range;
   logic              is_zero;
   logic              hit;
   logic [DATA_W-1:0] base;
   logic [DATA_W-1:0] value_d;
   logic [DATA_W-1:0] rd_q;

   always_comb begin
      in_range = int'(sel_i) < DEPTH;
      is_zero  = (ZERO_REG != 0) && (sel_i == '0);
      base     = '0;
      if (in_range && !is_zero) base = mem_i[sel_i];
      hit      = (BYPASS != 0) && wr_acc_i && (wr_sel_i == sel_i);
      value_d  = base;
      if (hit) begin
         value_d = DATA_W'(byte_merge(MAX_DW'(base), MAX_DW'(wr_data_i), MAX_BYTES'(wr_be_i)));
      end
   end

   // The register always exists; with READ_REG=0 it is simply not selected.
   always_ff @(posedge clk) begin
      if (!rst_n) rd_q <= '0;
      else        rd_q <= value_d;
   end

   assign rd_data_o = (READ_REG != 0) ? rd_q : value_d;

endmodule

// File: rtl/reg_file_multi.sv
// Parametrised register file: NUM_RD read ports, one byte-masked write port, bulk clear engine.
//
//   state | meaning
//   IDLE  | normal operation, writes accepted, clearReq starts a clear
//   CLEAR | zeroing storage[cnt_q] each cycle, writes dropped
module reg_file_multi
   import regfile_pkg::*;
#(
   parameter int  DATA_W   = 32,
   parameter int  DEPTH    = 32,
   parameter int  NUM_RD   = 2,
   parameter int  ZERO_REG = 1,
   parameter int  BYPASS   = 1,
   parameter int  READ_REG = 0,
   localparam int ADDR_W   = $clog2(DEPTH)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_RD*ADDR_W-1:0] regReadSel,
   output logic [NUM_RD*DATA_W-1:0] regReadData,
   input  logic [ADDR_W-1:0]        regWriteSel,
   input  logic                     writeEnable,
   input  logic [DATA_W/8-1:0]      byteEnable,
   input  logic [DATA_W-1:0]        writeData,
   input  logic                     clearReq,
   output logic                     clearBusy,
   output logic                     writeReady
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   clr_state_e        state_q;
   logic [ADDR_W-1:0] cnt_q;
   logic              busy_q;
   logic              wr_acc;
   logic [DATA_W-1:0] wr_merged_d;

   assign clearBusy  = busy_q;
   assign writeReady = !busy_q;

   always_comb begin
      wr_acc = writeEnable && !busy_q && (int'(regWriteSel) < DEPTH)
               && !((ZERO_REG != 0) && (regWriteSel == '0));
      wr_merged_d = DATA_W'(byte_merge(MAX_DW'(mem_q[regWriteSel]), MAX_DW'(writeData),
                                       MAX_BYTES'(byteEnable)));
   end

   // Clear and external write are exclusive: writes are refused whenever busy_q is set.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (state_q == CLEAR) begin
         mem_q[cnt_q] <= '0;
      end else if (wr_acc) begin
         mem_q[regWriteSel] <= wr_merged_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (clearReq) begin
                  state_q <= CLEAR;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
               end
            end
            CLEAR: begin
               if (int'(cnt_q) == DEPTH - 1) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      reg_file_read_port #(
         .DATA_W   (DATA_W),
         .DEPTH    (DEPTH),
         .ADDR_W   (ADDR_W),
         .ZERO_REG (ZERO_REG),
         .BYPASS   (BYPASS),
         .READ_REG (READ_REG)
      ) u_rd (
         .clk       (clk),
         .rst_n     (rst_n),
         .sel_i     (regReadSel[k*ADDR_W +: ADDR_W]),
         .mem_i     (mem_q),
         .wr_acc_i  (wr_acc),
         .wr_sel_i  (regWriteSel),
         .wr_be_i   (byteEnable),
         .wr_data_i (writeData),
         .rd_data_o (regReadData[k*DATA_W +: DATA_W])
      );
   end

endmodule
